// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte helpers for the encryption core.
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  localparam int AES_NUM_ROUNDS = 10;

  // Forward S-box, indexed by the input byte value.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Top bit of byte s(r,c) in a 128-bit block; byte 0 (s0,0) sits at [127:120], column-major.
  function automatic int byte_msb(input int r, input int c);
    return 127 - 8 * (4 * c + r);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One AES encryption round: SubBytes -> ShiftRows -> MixColumns (skipped on the last round) -> AddRoundKey.
module aes_enc_round
  import aes_pkg::*;
(
  input  aes_block_t i_data,
  input  aes_block_t i_key,
  input  logic       i_last,
  output aes_block_t o_data
);

  logic [7:0] sr [4][4];  // [row][col] after SubBytes + ShiftRows
  logic [7:0] mc [4][4];  // [row][col] after MixColumns

  // SubBytes fused with ShiftRows: row r takes its bytes from column c+r.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can leave it unassigned and infer a latch.
    sr = '{default: 8'h00};
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[r][c] = sbox(i_data[byte_msb(r, (c + r) % 4) -: 8]);
      end
    end
  end

  // MixColumns: each output byte is 2*a(r) ^ 3*a(r+1) ^ a(r+2) ^ a(r+3) within its column.
  always_comb begin
    mc = '{default: 8'h00};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        mc[r][c] = xtime(sr[r][c]) ^ xtime(sr[(r + 1) % 4][c]) ^ sr[(r + 1) % 4][c]
                 ^ sr[(r + 2) % 4][c] ^ sr[(r + 3) % 4][c];
      end
    end
  end

  // AddRoundKey on either the mixed or, for the final round, the unmixed state.
  always_comb begin
    o_data = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o_data[byte_msb(r, c) -: 8] = (i_last ? sr[r][c] : mc[r][c]) ^ i_key[byte_msb(r, c) -: 8];
      end
    end
  end

endmodule

// File: rtl/aes_encryption.sv
// Iterative AES-128 encryption core: one round per clock, round keys fetched by address,
// ciphertext held for the downstream FIFO until it is not full.
module aes_encryption
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int KEY_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  read_fifo,
  input  logic [127:0]          fifo_in,
  output logic                  in_ready,
  input  logic [127:0]          round_key_0,
  output logic [KEY_ADDR_W-1:0] round_key_addr,
  input  logic [127:0]          round_key_input,
  input  logic                  is_full,
  output logic [127:0]          data_output,
  output logic                  data_valid,
  output logic                  data_done
);

  localparam logic [KEY_ADDR_W-1:0] LAST_RND = KEY_ADDR_W'(NUM_ROUNDS);

  aes_state_e            fsm;
  aes_block_t            state_q;
  logic [KEY_ADDR_W-1:0] rnd;
  logic                  valid_q;
  logic                  last_round;
  logic                  load;
  aes_block_t            round_out;

  assign last_round = (rnd == LAST_RND);

  aes_enc_round u_round (
    .i_data (state_q),
    .i_key  (round_key_input),
    .i_last (last_round),
    .o_data (round_out)
  );

  // A block can enter when idle, or in the same cycle the finished ciphertext drains.
  assign in_ready       = (fsm == IDLE) || ((fsm == DONE) && !is_full);
  assign load           = read_fifo && in_ready;
  assign round_key_addr = (fsm == ROUND) ? rnd : '0;
  assign data_output    = state_q;
  assign data_valid     = valid_q;
  assign data_done      = valid_q && !is_full;

  // Control FSM and datapath registers: load with whitening, ten rounds, then hold until drained.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fsm     <= IDLE;
      // NOTE: the state register is reset too, because data_output must read zero right after reset.
      state_q <= '0;
      rnd     <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the statement order.
      case (fsm)
        IDLE: begin
          if (load) begin
            state_q <= fifo_in ^ round_key_0;
            rnd     <= KEY_ADDR_W'(1);
            fsm     <= ROUND;
          end
        end
        ROUND: begin
          state_q <= round_out;
          if (last_round) begin
            fsm     <= DONE;
            valid_q <= 1'b1;
          end else begin
            rnd <= rnd + KEY_ADDR_W'(1);
          end
        end
        DONE: begin
          if (!is_full) begin
            valid_q <= 1'b0;
            if (load) begin
              state_q <= fifo_in ^ round_key_0;
              rnd     <= KEY_ADDR_W'(1);
              fsm     <= ROUND;
            end else begin
              fsm <= IDLE;
            end
          end
        end
        default: begin
          fsm     <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encryption.sv
// Self-checking bench for aes_encryption against a GF(2^8)-arithmetic AES-128 reference model.
module tb_aes_encryption;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;

  logic         clk;
  logic         n_rst;
  logic         read_fifo;
  logic [127:0] fifo_in;
  logic         in_ready;
  logic [127:0] round_key_0;
  logic [3:0]   round_key_addr;
  logic [127:0] round_key_input;
  logic         is_full;
  logic [127:0] data_output;
  logic         data_valid;
  logic         data_done;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] rk [16];

  aes_encryption dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .read_fifo       (read_fifo),
    .fifo_in         (fifo_in),
    .in_ready        (in_ready),
    .round_key_0     (round_key_0),
    .round_key_addr  (round_key_addr),
    .round_key_input (round_key_input),
    .is_full         (is_full),
    .data_output     (data_output),
    .data_valid      (data_valid),
    .data_done       (data_done)
  );

  // Asynchronous round-key store served from the bench key schedule.
  assign round_key_0     = rk[0];
  assign round_key_input = rk[round_key_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    return {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endfunction

  // State after the first nr rounds (nr=0: initial AddRoundKey only, nr=10: ciphertext).
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key, input int nr);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [127:0] blk, k;
    blk = pt ^ key;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = blk[127 - 8 * (r + 4 * c) -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sbox_t[s[r][(c + r) % 4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          s[r][c] = (rd == 10) ? t[r][c]
                  : gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r + 1) % 4][c]) ^ t[(r + 2) % 4][c] ^ t[(r + 3) % 4][c];
      k = round_key(key, rd);
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] ^= k[127 - 8 * (r + 4 * c) -: 8];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) blk[127 - 8 * (r + 4 * c) -: 8] = s[r][c];
    return blk;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input logic [127:0] key);
    for (int r = 0; r < 16; r++) rk[r] = (r <= 10) ? round_key(key, r) : '0;
  endtask

  task automatic idle_check(input string tag);
    is_full   = 1'b0;
    read_fifo = 1'b0;
    #1;
    check($sformatf("%s_idle_valid", tag), data_valid, 0);
    check($sformatf("%s_idle_done", tag), data_done, 0);
    check($sformatf("%s_idle_ready", tag), in_ready, 1);
    check($sformatf("%s_idle_addr", tag), round_key_addr, 0);
  endtask

  // Ten round cycles after acceptance; optional is_full assertion and a stray read_fifo pulse.
  task automatic rounds_phase(input logic [127:0] pt, input logic [127:0] key,
                              input int full_from, input int pulse_at, input string tag);
    for (int n = 0; n < 10; n++) begin
      is_full = (full_from >= 0) && (n >= full_from);
      if (pulse_at >= 0 && n == pulse_at) begin
        read_fifo = 1'b1;
        fifo_in   = {$urandom, $urandom, $urandom, $urandom};
      end else if (pulse_at >= 0 && n == pulse_at + 1) begin
        read_fifo = 1'b0;
      end
      #1;
      check($sformatf("%s_r%0d_addr", tag, n), round_key_addr, n + 1);
      check($sformatf("%s_r%0d_ready", tag, n), in_ready, 0);
      check($sformatf("%s_r%0d_valid", tag, n), data_valid, 0);
      check($sformatf("%s_r%0d_done", tag, n), data_done, 0);
      check($sformatf("%s_r%0d_state", tag, n), data_output, aes_ref(pt, key, n));
      tick();
    end
  endtask

  // Ciphertext held while is_full; returns on the data_done cycle (before its clock edge).
  task automatic done_phase(input logic [127:0] pt, input logic [127:0] key,
                            input int full_to, input string tag);
    logic [127:0] exp_ct;
    exp_ct = aes_ref(pt, key, 10);
    for (int n = 10; n <= 10 + full_to; n++) begin
      is_full = (n < full_to);
      #1;
      check($sformatf("%s_c%0d_valid", tag, n), data_valid, 1);
      check($sformatf("%s_c%0d_ct", tag, n), data_output, exp_ct);
      check($sformatf("%s_c%0d_addr", tag, n), round_key_addr, 0);
      if (is_full) begin
        check($sformatf("%s_c%0d_done", tag, n), data_done, 0);
        check($sformatf("%s_c%0d_ready", tag, n), in_ready, 0);
        tick();
      end else begin
        check($sformatf("%s_c%0d_done", tag, n), data_done, 1);
        check($sformatf("%s_c%0d_ready", tag, n), in_ready, 1);
        return;
      end
    end
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] key, input int full_from,
                           input int full_to, input int pulse_at, input string tag);
    set_key(key);
    fifo_in   = pt;
    read_fifo = 1'b1;
    is_full   = 1'b0;
    #1;
    check($sformatf("%s_accept_ready", tag), in_ready, 1);
    tick();
    read_fifo = 1'b0;
    rounds_phase(pt, key, full_from, pulse_at, tag);
    done_phase(pt, key, full_to, tag);
    tick();
    idle_check(tag);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_rst     = 1'b0;
    read_fifo = 1'b0;
    fifo_in   = '0;
    is_full   = 1'b0;
    for (int r = 0; r < 16; r++) rk[r] = '0;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    check("model_c1_ct", aes_ref(C1_PT, C1_KEY, 10), C1_CT);
    check("model_b_r1", aes_ref(B_PT, B_KEY, 1), B_R1);
    check("model_b_ct", aes_ref(B_PT, B_KEY, 10), B_CT);

    #3;
    check("rst_data_output", data_output, 0);
    check("rst_valid", data_valid, 0);
    check("rst_done", data_done, 0);
    check("rst_addr", round_key_addr, 0);
    check("rst_ready", in_ready, 1);
    tick();
    tick();
    n_rst = 1'b1;
    idle_check("post_rst");

    run_block(C1_PT, C1_KEY, -1, 0, -1, "c1");
    run_block(B_PT, B_KEY, -1, 0, -1, "appb");
    run_block(C1_PT, C1_KEY, 8, 20, -1, "stall");
    run_block(B_PT, B_KEY, -1, 0, 3, "busy_load");

    // Back-to-back: read_fifo stays high with two queued blocks.
    set_key(C1_KEY);
    fifo_in   = C1_PT;
    read_fifo = 1'b1;
    is_full   = 1'b0;
    #1;
    check("b2b_accept_ready", in_ready, 1);
    tick();
    fifo_in = B_PT;
    rounds_phase(C1_PT, C1_KEY, -1, -1, "b2b_a");
    set_key(B_KEY);
    done_phase(C1_PT, C1_KEY, 0, "b2b_a");
    tick();
    read_fifo = 1'b0;
    rounds_phase(B_PT, B_KEY, -1, -1, "b2b_b");
    done_phase(B_PT, B_KEY, 0, "b2b_b");
    tick();
    idle_check("b2b");

    // Reset in the middle of round 5, then a fresh block.
    set_key(C1_KEY);
    fifo_in   = C1_PT;
    read_fifo = 1'b1;
    tick();
    read_fifo = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    #1;
    check("mid_addr_before_rst", round_key_addr, 5);
    n_rst = 1'b0;
    #1;
    check("mid_rst_data_output", data_output, 0);
    check("mid_rst_valid", data_valid, 0);
    check("mid_rst_done", data_done, 0);
    check("mid_rst_addr", round_key_addr, 0);
    check("mid_rst_ready", in_ready, 1);
    tick();
    tick();
    n_rst = 1'b1;
    idle_check("mid_rst_release");
    run_block(C1_PT, C1_KEY, -1, 0, -1, "after_rst");

    // Random blocks with random keys, stalls and stray loads.
    for (int i = 0; i < 6; i++) begin
      logic [127:0] pt, key;
      int ff, ft, pa;
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      ff  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : -1;
      ft  = (ff >= 0) ? int'($urandom_range(10, 16)) : 0;
      pa  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : -1;
      run_block(pt, key, ff, ft, pa, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_encryption.md
Name: aes_encryption

Overview:
Iterative AES-128 encryption core, the transmit-side counterpart of the decryption pipeline.
- Accepts one 128-bit plaintext block from the input FIFO.
- Runs the initial AddRoundKey, then 10 rounds at one round per clock. Round keys come from the shared round-key store through an address port.
- Presents the ciphertext to the downstream FIFO with a full-based stall.

Parameters:
NUM_ROUNDS, 10, number of cipher rounds (AES-128 only; other values unsupported)
KEY_ADDR_W, 4, width of round_key_addr

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
read_fifo  in  1  load strobe; block on fifo_in accepted when read_fifo && in_ready
fifo_in  in  128  plaintext block; bits[127:120] = byte 0 (s0,0), column-major
in_ready  out  1  core can accept a block this cycle
round_key_0  in  128  round key 0 (raw cipher key), static while busy
round_key_addr  out  4  index of round key needed this cycle
round_key_input  in  128  round key at round_key_addr, combinational same-cycle lookup
is_full  in  1  downstream FIFO full; blocks output transfer
data_output  out  128  ciphertext, valid when data_valid
data_valid  out  1  ciphertext held on data_output
data_done  out  1  one-cycle pulse: ciphertext transferred (data_valid && !is_full)

Behaviour:
- Reset (n_rst low, any time including mid-block): FSM to IDLE, round counter 0, state register 0.
  - Outputs after reset: data_output=0, data_valid=0, data_done=0, round_key_addr=0, in_ready=1.
  - Any in-flight block is discarded.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1, round_key_addr=0.
  - On read_fifo: state <= fifo_in ^ round_key_0, rnd <= 1, go to ROUND.
- ROUND (rnd = 1..10):
  - in_ready=0, round_key_addr=rnd.
  - state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), round_key_input), with MixColumns bypassed when rnd==10.
  - rnd increments each cycle. After the rnd==10 update, go to DONE.
  - is_full is ignored in ROUND; rounds never stall.
  - read_fifo is ignored in ROUND; the block is not accepted and the FIFO is not popped.
- DONE:
  - data_valid=1, data_output=state, round_key_addr=0.
  - If is_full=1: hold state and data_output unchanged, in_ready=0.
  - If is_full=0: data_done=1 this cycle and in_ready=1.
    - With read_fifo the same cycle: load the new block (fifo_in ^ round_key_0) and go to ROUND (back-to-back).
    - Otherwise go to IDLE.
- Latency:
  - Accept at edge 0; rounds at edges 1..10; data_valid high after edge 10.
  - 11 cycles from accept to first data_valid.
  - Sustained throughput: one block per 11 cycles.
- data_output is driven from the state register in all states. It is only meaningful while data_valid=1.
- data_done is never asserted without data_valid.
- rnd is 4 bits and never wraps: it stops at 10 and is cleared on load.
- round_key_addr is combinational from the FSM and rnd, glitch-tolerant; the key store is asynchronous read.

Decomposition:
- Shared package aes_pkg:
  - aes_block_t (logic [127:0]), aes_state_e {IDLE, ROUND, DONE}
  - AES_NUM_ROUNDS=10
  - S-box constant array
  - byte-index helper function for the column-major mapping
- One sub-module aes_enc_round: combinational SubBytes -> ShiftRows -> MixColumns (bypass via i_last) -> AddRoundKey.
  - Ports: i_data, i_key, i_last, o_data.
  - Keeps the top module as FSM + registers only.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f (bench key-schedule model serves round_key_input by address), fifo_in 00112233445566778899aabbccddeeff -> data_valid exactly 11 cycles after accept, data_output 69c4e0d86a7b0430d8cdb78070b4c55a, data_done one cycle; round_key_addr sequence 1..10.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; state after round 1 = a49c7ff2689f352b6b5bea43026a5049.
- Stall: is_full=1 from cycle 8 to 20 -> data_valid held, data_output stable, data_done=0, in_ready=0. is_full drops -> single data_done pulse, then IDLE.
- Back-to-back: read_fifo held high with two queued blocks (C.1 then App. B vectors) -> second accepted on first's data_done cycle; second ciphertext valid 11 cycles later; no FIFO pop during ROUND.
- Reset mid-round: n_rst low at round 5 -> all outputs 0 and in_ready=1 immediately (async). After release, a new C.1 block encrypts correctly.
- Ignore load while busy: pulse read_fifo during ROUND -> no state change, final ciphertext unaffected.
